// File: rtl/keypad_scan_ctrl.sv
// 4x4 active-low keypad scanner: column stepping, frame debounce, key-code event FIFO.
// Optional KEYPAD_RELEASE_EVT_EN also queues release events (code | 8'h80) after presses.
module keypad_scan_ctrl #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic        iclk,
    input  logic        inrest,
    input  logic [3:0]  iROW,
    output logic [3:0]  oCOL,
    input  logic        iRD,
    input  logic        iCLR_OVF,
    output logic [7:0]  oKEYNUM,
    output logic        oVALID,
    output logic        oIRQ,
    output logic [15:0] oKEYST,
    output logic        oOVF
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DB_MAX    = DW'(DEBOUNCE_FRAMES);
    localparam logic [AW:0]   FULL      = (AW+1)'(FIFO_DEPTH);

    typedef enum logic {SCAN, PUSH} state_t;

    state_t        state_q, state_d;
    logic [1:0]    col_q, col_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    sync1_q, sync2_q;
    logic [15:0]   raw_q, raw_d, prev_q, prev_d, keyst_q, keyst_d, pend_q, pend_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
`ifdef KEYPAD_RELEASE_EVT_EN
    logic [15:0]   rel_q, rel_d;
`endif

    logic [15:0]   src;
    logic [3:0]    low_idx;
    logic          push_req;
    logic [7:0]    push_code;

    function automatic logic [7:0] key_code(input logic [3:0] idx);
        case (idx)
            4'd0:  key_code = 8'h01;  4'd1:  key_code = 8'h02;
            4'd2:  key_code = 8'h03;  4'd3:  key_code = 8'h0A;
            4'd4:  key_code = 8'h04;  4'd5:  key_code = 8'h05;
            4'd6:  key_code = 8'h06;  4'd7:  key_code = 8'h0B;
            4'd8:  key_code = 8'h07;  4'd9:  key_code = 8'h08;
            4'd10: key_code = 8'h09;  4'd11: key_code = 8'h0C;
            4'd12: key_code = 8'h00;  4'd13: key_code = 8'h0F;
            4'd14: key_code = 8'h0E;  default: key_code = 8'h0D;
        endcase
    endfunction

    // Presses drain before releases; lowest bit index first within each set.
    always_comb begin
`ifdef KEYPAD_RELEASE_EVT_EN
        src = (pend_q != 16'h0) ? pend_q : rel_q;
`else
        src = pend_q;
`endif
        low_idx = 4'd0;
        for (int i = 15; i >= 0; i--)
            if (src[i]) low_idx = 4'(i);
    end

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        presc_d   = presc_q;
        raw_d     = raw_q;
        prev_d    = prev_q;
        keyst_d   = keyst_q;
        dcnt_d    = dcnt_q;
        pend_d    = pend_q;
`ifdef KEYPAD_RELEASE_EVT_EN
        rel_d     = rel_q;
`endif
        push_req  = 1'b0;
        push_code = 8'hFF;
        case (state_q)
            SCAN: begin
                if (presc_q == PRESC_MAX) begin
                    presc_d = '0;
                    col_d   = col_q + 2'd1;
                    for (int r = 0; r < 4; r++)
                        raw_d[{2'(r), col_q}] = ~sync2_q[r];
                    if (col_q == 2'd3) begin
                        if (raw_d == prev_q)
                            dcnt_d = (dcnt_q == DB_MAX) ? DB_MAX : dcnt_q + DW'(1);
                        else
                            dcnt_d = DW'(1);
                        prev_d = raw_d;
                        if (dcnt_d == DB_MAX && raw_d != keyst_q) begin
                            keyst_d = raw_d;
                            pend_d  = raw_d & ~keyst_q;
`ifdef KEYPAD_RELEASE_EVT_EN
                            rel_d   = keyst_q & ~raw_d;
                            if (pend_d != 16'h0 || rel_d != 16'h0) state_d = PUSH;
`else
                            if (pend_d != 16'h0) state_d = PUSH;
`endif
                        end
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            PUSH: begin
                push_req = 1'b1;
`ifdef KEYPAD_RELEASE_EVT_EN
                if (pend_q != 16'h0) begin
                    push_code       = key_code(low_idx);
                    pend_d[low_idx] = 1'b0;
                end else begin
                    push_code      = key_code(low_idx) | 8'h80;
                    rel_d[low_idx] = 1'b0;
                end
                if (pend_d == 16'h0 && rel_d == 16'h0) state_d = SCAN;
`else
                push_code       = key_code(low_idx);
                pend_d[low_idx] = 1'b0;
                if (pend_d == 16'h0) state_d = SCAN;
`endif
            end
            default: state_d = SCAN;
        endcase
    end

    always_ff @(posedge iclk or negedge inrest) begin
        if (!inrest) begin
            state_q <= SCAN;
            col_q   <= 2'd0;
            presc_q <= '0;
            sync1_q <= 4'h0;
            sync2_q <= 4'h0;
            raw_q   <= 16'h0;
            prev_q  <= 16'h0;
            keyst_q <= 16'h0;
            dcnt_q  <= '0;
            pend_q  <= 16'h0;
`ifdef KEYPAD_RELEASE_EVT_EN
            rel_q   <= 16'h0;
`endif
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            presc_q <= presc_d;
            sync1_q <= iROW;
            sync2_q <= sync1_q;
            raw_q   <= raw_d;
            prev_q  <= prev_d;
            keyst_q <= keyst_d;
            dcnt_q  <= dcnt_d;
            pend_q  <= pend_d;
`ifdef KEYPAD_RELEASE_EVT_EN
            rel_q   <= rel_d;
`endif
        end
    end

    // Event FIFO; head and valid are registered from the post-operation state.
    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d, head_idx;
    logic [AW:0] cnt_q, cnt_d;
    logic        do_push, do_pop, ovf_set;
    logic [7:0]  head_q, head_d;
    logic        valid_q, irq_q, ovf_q, ovf_d;

    always_comb begin
        do_pop   = iRD && (cnt_q != '0);
        do_push  = push_req && ((cnt_q != FULL) || do_pop);
        ovf_set  = push_req && (cnt_q == FULL) && !do_pop;
        wr_d     = do_push ? wr_q + AW'(1) : wr_q;
        rd_d     = do_pop ? rd_q + AW'(1) : rd_q;
        cnt_d    = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        head_idx = rd_d;
        if (cnt_d == '0)
            head_d = 8'hFF;
        else if (do_push && wr_q == head_idx)
            head_d = push_code;
        else
            head_d = mem_q[head_idx];
        ovf_d = (ovf_q & ~iCLR_OVF) | ovf_set;
    end

    always_ff @(posedge iclk) begin
        if (do_push) mem_q[wr_q] <= push_code;
    end

    always_ff @(posedge iclk or negedge inrest) begin
        if (!inrest) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            head_q  <= 8'hFF;
            valid_q <= 1'b0;
            irq_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            head_q  <= head_d;
            valid_q <= (cnt_d != '0);
            irq_q   <= (cnt_d != '0);
            ovf_q   <= ovf_d;
        end
    end

    assign oCOL    = ~(4'b0001 << col_q);
    assign oKEYNUM = head_q;
    assign oVALID  = valid_q;
    assign oIRQ    = irq_q;
    assign oKEYST  = keyst_q;
    assign oOVF    = ovf_q;
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with a behavioural keypad matrix on the pins.
module tb_keypad_scan_ctrl;
    logic        iclk = 1'b0;
    logic        inrest = 1'b0;
    logic [3:0]  iROW;
    logic [3:0]  oCOL;
    logic        iRD = 1'b0;
    logic        iCLR_OVF = 1'b0;
    logic [7:0]  oKEYNUM;
    logic        oVALID, oIRQ, oOVF;
    logic [15:0] oKEYST;
    logic [15:0] keys = 16'h0;

    int checks = 0;
    int errors = 0;

    keypad_scan_ctrl #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(2), .FIFO_DEPTH(4)) dut (
        .iclk(iclk), .inrest(inrest), .iROW(iROW), .oCOL(oCOL), .iRD(iRD),
        .iCLR_OVF(iCLR_OVF), .oKEYNUM(oKEYNUM), .oVALID(oVALID), .oIRQ(oIRQ),
        .oKEYST(oKEYST), .oOVF(oOVF)
    );

    always #5 iclk = ~iclk;

    // A pressed key pulls its row low while its column is driven low.
    always_comb begin
        for (int r = 0; r < 4; r++)
            iROW[r] = ~|(keys[r*4 +: 4] & ~oCOL);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    task automatic pop();
        iRD = 1'b1;
        tick();
        iRD = 1'b0;
    endtask

    task automatic wait_keyst(input logic [15:0] exp, input string tag);
        int n;
        n = 0;
        while (oKEYST !== exp && n < 200) begin
            tick();
            n++;
        end
        chk(tag, {16'h0, oKEYST}, {16'h0, exp});
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (oVALID !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk(tag, {31'h0, oVALID}, 32'h1);
    endtask

    logic [3:0] pat [4];
    logic [7:0] ovf_codes [5];

    initial begin
        pat = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        ovf_codes = '{8'h01, 8'h02, 8'h03, 8'h0A, 8'h04};

        #12;
        chk("rst_col",   {28'h0, oCOL},    32'hE);
        chk("rst_keyst", {16'h0, oKEYST},  32'h0);
        chk("rst_valid", {31'h0, oVALID},  32'h0);
        chk("rst_irq",   {31'h0, oIRQ},    32'h0);
        chk("rst_keynum",{24'h0, oKEYNUM}, 32'hFF);
        chk("rst_ovf",   {31'h0, oOVF},    32'h0);
        @(negedge iclk);
        inrest = 1'b1;

        // three idle frames: column steps every 4 clocks
        for (int n = 1; n <= 48; n++) begin
            tick();
            chk("col_seq", {28'h0, oCOL}, {28'h0, pat[(n / 4) % 4]});
        end
        chk("idle_keyst", {16'h0, oKEYST}, 32'h0);
        chk("idle_valid", {31'h0, oVALID}, 32'h0);
        chk("idle_keynum", {24'h0, oKEYNUM}, 32'hFF);

        // single key r1c2
        keys = 16'h0040;
        wait_keyst(16'h0040, "r1c2_keyst");
        wait_valid("r1c2_valid");
        chk("r1c2_code", {24'h0, oKEYNUM}, 32'h06);
        chk("r1c2_irq", {31'h0, oIRQ}, 32'h1);
        pop();
        chk("r1c2_pop_valid", {31'h0, oVALID}, 32'h0);
        chk("r1c2_pop_keynum", {24'h0, oKEYNUM}, 32'hFF);
        chk("r1c2_pop_irq", {31'h0, oIRQ}, 32'h0);
        keys = 16'h0;
        wait_keyst(16'h0000, "r1c2_release");
`ifdef KEYPAD_RELEASE_EVT_EN
        wait_valid("r1c2_rel_valid");
        chk("r1c2_rel_code", {24'h0, oKEYNUM}, 32'h86);
        pop();
`endif
        repeat (40) tick();
        chk("release_noevt", {31'h0, oVALID}, 32'h0);

        // bouncing key: alternate each frame, never stable for 2 frames
        for (int i = 0; i < 6; i++) begin
            keys = keys ^ 16'h0040;
            repeat (16) tick();
            chk("bounce_keyst", {16'h0, oKEYST}, 32'h0);
        end
        keys = 16'h0;
        repeat (48) tick();
        chk("bounce_valid", {31'h0, oVALID}, 32'h0);

        // two keys at once: 2 PUSH cycles freeze the column
        keys = 16'h2001;
        wait_keyst(16'h2001, "dual_keyst");
        repeat (4) tick();
        chk("freeze_p4", {28'h0, oCOL}, 32'hE);
        tick();
        chk("freeze_p5", {28'h0, oCOL}, 32'hE);
        tick();
        chk("freeze_p6", {28'h0, oCOL}, 32'hD);
        chk("dual_valid", {31'h0, oVALID}, 32'h1);
        chk("dual_code0", {24'h0, oKEYNUM}, 32'h01);
        pop();
        chk("dual_code1", {24'h0, oKEYNUM}, 32'h0F);
        pop();
        chk("dual_empty", {24'h0, oKEYNUM}, 32'hFF);
        keys = 16'h0;
        wait_keyst(16'h0000, "dual_release");
`ifdef KEYPAD_RELEASE_EVT_EN
        wait_valid("dual_rel_valid");
        chk("dual_rel0", {24'h0, oKEYNUM}, 32'h81);
        pop();
        chk("dual_rel1", {24'h0, oKEYNUM}, 32'h8F);
        pop();

        // release of r2c3 queues 0C then 8C
        keys = 16'h0800;
        wait_keyst(16'h0800, "r2c3_keyst");
        keys = 16'h0;
        wait_keyst(16'h0000, "r2c3_release");
        repeat (3) tick();
        chk("r2c3_press", {24'h0, oKEYNUM}, 32'h0C);
        pop();
        chk("r2c3_rel", {24'h0, oKEYNUM}, 32'h8C);
        pop();
        chk("r2c3_empty", {31'h0, oVALID}, 32'h0);
`else
        // five presses, no reads: fifth dropped
        for (int i = 0; i < 5; i++) begin
            keys = 16'h1 << i;
            wait_keyst(keys, "ovf_press");
            keys = 16'h0;
            wait_keyst(16'h0000, "ovf_release");
        end
        chk("ovf_flag", {31'h0, oOVF}, 32'h1);
        chk("ovf_head", {24'h0, oKEYNUM}, {24'h0, ovf_codes[0]});
        iCLR_OVF = 1'b1;
        tick();
        iCLR_OVF = 1'b0;
        chk("ovf_clear", {31'h0, oOVF}, 32'h0);

        // push and pop together while full: no overflow
        keys = 16'h0020;
        wait_keyst(16'h0020, "full_press");
        iRD = 1'b1;
        tick();
        iRD = 1'b0;
        chk("full_pushpop_ovf", {31'h0, oOVF}, 32'h0);
        chk("full_head1", {24'h0, oKEYNUM}, {24'h0, ovf_codes[1]});
        pop();
        chk("full_head2", {24'h0, oKEYNUM}, {24'h0, ovf_codes[2]});
        pop();
        chk("full_head3", {24'h0, oKEYNUM}, {24'h0, ovf_codes[3]});
        pop();
        chk("full_head4", {24'h0, oKEYNUM}, 32'h05);
        pop();
        chk("full_empty", {24'h0, oKEYNUM}, 32'hFF);
        chk("full_empty_valid", {31'h0, oVALID}, 32'h0);
        pop();
        chk("pop_empty_ignored", {31'h0, oVALID}, 32'h0);
        keys = 16'h0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
- Scan sequencer for the 4x4 active-low keypad matrix.
- Steps the column drive at a programmable rate and samples the rows through a synchronizer.
- Debounces whole scan frames, then serially pushes a key code for each new press into a small event FIFO.
- Sits between the keypad pins and the interrupt/bus wrapper; oIRQ is a level interrupt.

Parameters:
- SCAN_DIV, 1000: clock cycles per column step; minimum 4.
- DEBOUNCE_FRAMES, 4: consecutive identical full frames required before a commit; minimum 1.
- FIFO_DEPTH, 4: event FIFO entries; power of two, 2..16.

Ports:
- iclk  in  1  clock.
- inrest  in  1  reset; asynchronous, active-low.
- iROW  in  4  row inputs, pulled up; 0 = key pressed.
- oCOL  out  4  column drive; exactly one bit low.
- iRD  in  1  one-cycle pop strobe for the FIFO head.
- iCLR_OVF  in  1  clears oOVF.
- oKEYNUM  out  8  FIFO head key code; 8'hFF when empty.
- oVALID  out  1  FIFO non-empty.
- oIRQ  out  1  registered level; equals oVALID.
- oKEYST  out  16  debounced key bitmap; bit = row*4+col; 1 = pressed.
- oOVF  out  1  sticky overflow flag.

Behaviour:
- Reset values (inrest low, asynchronous):
  - col index 0, so oCOL = 4'b1110; prescaler 0.
  - synchronizer flops, raw frame, previous frame and oKEYST = 0; debounce count 0.
  - FIFO empty: oVALID = 0, oIRQ = 0, oKEYNUM = 8'hFF; oOVF = 0; state SCAN.
- Column drive: oCOL = 1110 / 1101 / 1011 / 0111 for column 0 / 1 / 2 / 3.
- Row sampling: iROW passes through a 2-flop synchronizer.
- Prescaler (SCAN state only):
  - counts 0..SCAN_DIV-1.
  - at count SCAN_DIV-1: raw[r*4+col] <= ~iROW_sync[r] for r = 0..3, then col increments (3 wraps to 0) and prescaler returns to 0.
- Frame end (sample taken at col 3):
  - if raw frame == previous frame: debounce count increments, saturating at DEBOUNCE_FRAMES; otherwise count = 1.
  - previous frame <= raw frame.
  - when count first reaches DEBOUNCE_FRAMES and raw != oKEYST: commit.
    - pending = raw & ~oKEYST.
    - oKEYST <= raw on the same cycle.
    - state -> PUSH if pending != 0.
- PUSH state:
  - prescaler and column frozen.
  - one event per clock for the lowest set bit of pending; that bit is cleared.
  - return to SCAN when pending becomes 0.
- Key code map (row r, col c):
  - r0: 01, 02, 03, 0A.
  - r1: 04, 05, 06, 0B.
  - r2: 07, 08, 09, 0C.
  - r3: 00, 0F, 0E, 0D.
- FIFO:
  - push and pop on the same cycle are both honoured, including when full.
  - push when full without a pop: event dropped, oOVF <= 1.
  - pop when empty: ignored.
  - oKEYNUM and oVALID are registered and update the cycle after a push or pop.
- Overflow flag: iCLR_OVF clears oOVF; if a new overflow occurs on the same cycle, set wins.
- Multiple keys pressed: every new key is queued in bit-index order.
- Release: updates oKEYST only; no event is queued.
- inrest asserted mid-PUSH: all pending events are discarded.

Optional Feature:
- Macro: KEYPAD_RELEASE_EVT_EN.
- Defined:
  - commit also forms released = oKEYST & ~raw.
  - PUSH enqueues all press events first, then release events.
  - release code = press code | 8'h80, same lowest-bit-first order.
- Undefined: release logic absent; only presses are queued.

Test Plan (SCAN_DIV=4, DEBOUNCE_FRAMES=2, FIFO_DEPTH=4):
- Reset, no keys, 3 frames -> oCOL sequence 1110, 1101, 1011, 0111 every 4 clocks; oKEYST=0; oVALID=0; oKEYNUM=FF.
- Hold key r1c2 (row1 low while oCOL=1011) -> after 2 stable frames oKEYST=16'h0040, oKEYNUM=06, oIRQ=1; iRD pulse -> oVALID=0 and oKEYNUM=FF the next cycle.
- r1c2 bounces (pressed 1 frame, released 1 frame, repeated) -> no commit, FIFO stays empty.
- Press r0c0 and r3c1 together -> oKEYST=16'h2001; FIFO holds 01 then 0F; column frozen for exactly 2 PUSH cycles.
- 5 single presses with no reads -> FIFO holds the first 4 codes, oOVF=1; iCLR_OVF -> oOVF=0; simultaneous pop+push when full -> no overflow.
- With KEYPAD_RELEASE_EVT_EN: press then release r2c3 -> FIFO holds 0C, then 8C.
